// File: rtl/serial_alu_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_pkg
// Shared opcodes, FSM state encoding and flag indices for serial_alu.
// Revision: 1.0
// ============================================================================
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLAG_ZF = 0;
  localparam int FLAG_CF = 1;
  localparam int FLAG_SF = 2;
  localparam int FLAG_OF = 3;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op != 3'b000) && (op != 3'b111);
  endfunction

  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_alu_digit_slice.sv
`default_nettype none
// ============================================================================
// Module  : alu_digit_slice
// Combinational DIGIT-bit logic unit and ripple adder for one digit.
// Revision: 1.0
// ============================================================================
module alu_digit_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic [2:0]       opcode,
  output logic [DIGIT-1:0] y,
  output logic             cout,
  output logic             c_msb
);
  import alu_pkg::*;

  logic [DIGIT-1:0] b_eff;
  logic [DIGIT-1:0] sum;
  logic [DIGIT:0]   carry;

  // Subtraction is A + ~B + 1; the +1 arrives as the initial carry.
  always_comb begin
    b_eff    = (opcode == OP_SUB) ? ~b : b;
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
  end

  always_comb begin
    y     = '0;
    cout  = 1'b0;
    c_msb = carry[DIGIT-1];
    case (opcode)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_NOR: y = ~(a | b);
      OP_XOR: y = a ^ b;
      OP_ADD, OP_SUB: begin
        y    = sum;
        cout = carry[DIGIT];
      end
      default: y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/serial_alu.sv
`default_nettype none
// ============================================================================
// Module  : serial_alu
// Digit-serial ALU: WIDTH-bit operands, DIGIT bits per clock, start/busy/done.
// Revision: 1.0
// ============================================================================
module serial_alu #(
  parameter int WIDTH = 4,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   C,
  output logic             ZF,
  output logic             CF,
  output logic             SF,
  output logic             OF
);
  import alu_pkg::*;

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = $clog2(N) + 1;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   c_q, c_d;
  logic [3:0]       flags_q, flags_d;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] y_dig;
  logic             slice_cout;
  logic             slice_cmsb;
  logic             accept;
  logic             last;
  logic             cf_fin;
  logic             of_fin;

  // Digit select from the latched operands.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int j = 0; j < N; j++) begin
      if (k_q == KW'(j)) begin
        a_dig = a_q[j*DIGIT +: DIGIT];
        b_dig = b_q[j*DIGIT +: DIGIT];
      end
    end
  end

  alu_digit_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a      (a_dig),
    .b      (b_dig),
    .cin    (carry_q),
    .opcode (op_q),
    .y      (y_dig),
    .cout   (slice_cout),
    .c_msb  (slice_cmsb)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    c_d     = c_q;
    flags_d = flags_q;
    accept  = start && op_is_legal(opcode);
    last    = (k_q == KW'(N - 1));
    // Carry-out of an ADD is the carry flag; for SUB it is inverted into a borrow.
    cf_fin  = op_is_arith(op_q) && (slice_cout ^ (op_q == OP_SUB));
    of_fin  = op_is_arith(op_q) && (slice_cmsb ^ slice_cout);

    case (state_q)
      ST_RUN: begin
        for (int j = 0; j < N; j++) begin
          if (k_q == KW'(j)) begin
            c_d[j*DIGIT +: DIGIT] = y_dig;
          end
        end
        carry_d = slice_cout;
        k_d     = k_q + KW'(1);
        if (last) begin
          state_d          = ST_DONE;
          c_d[WIDTH]       = cf_fin;
          flags_d[FLAG_ZF] = (c_d[WIDTH-1:0] == '0);
          flags_d[FLAG_CF] = cf_fin;
          flags_d[FLAG_SF] = c_d[WIDTH-1];
          flags_d[FLAG_OF] = of_fin;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Accepting from DONE as well as IDLE gives back-to-back operation.
    if ((state_q != ST_RUN) && accept) begin
      state_d = ST_RUN;
      a_d     = A;
      b_d     = B;
      op_d    = opcode;
      k_d     = '0;
      c_d     = '0;
      carry_d = (opcode == OP_SUB);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      c_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      flags_q <= flags_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign C    = c_q;
  assign ZF   = flags_q[FLAG_ZF];
  assign CF   = flags_q[FLAG_CF];
  assign SF   = flags_q[FLAG_SF];
  assign OF   = flags_q[FLAG_OF];

endmodule
`default_nettype wire

// File: tb/tb_serial_alu.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_alu
// Bench for serial_alu: WIDTH=4/DIGIT=1 and WIDTH=8/DIGIT=2 against a model.
// Revision: 1.0
// ============================================================================
module tb_serial_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_in [2];
  logic [2:0] op_in    [2];
  logic [7:0] a_in     [2];
  logic [7:0] b_in     [2];

  logic       busy0, done0, zf0, cf0, sf0, of0;
  logic [4:0] c0;
  logic       busy1, done1, zf1, cf1, sf1, of1;
  logic [8:0] c1;

  logic       busy_o [2];
  logic       done_o [2];
  logic [8:0] c_o    [2];
  logic [3:0] f_o    [2];

  always #5 clk = ~clk;

  serial_alu #(.WIDTH(4), .DIGIT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_in[0]), .opcode(op_in[0]),
    .A(a_in[0][3:0]), .B(b_in[0][3:0]), .busy(busy0), .done(done0),
    .C(c0), .ZF(zf0), .CF(cf0), .SF(sf0), .OF(of0)
  );

  serial_alu #(.WIDTH(8), .DIGIT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start_in[1]), .opcode(op_in[1]),
    .A(a_in[1]), .B(b_in[1]), .busy(busy1), .done(done1),
    .C(c1), .ZF(zf1), .CF(cf1), .SF(sf1), .OF(of1)
  );

  always_comb begin
    busy_o[0] = busy0;
    done_o[0] = done0;
    c_o[0]    = {4'b0000, c0};
    f_o[0]    = {zf0, cf0, sf0, of0};
    busy_o[1] = busy1;
    done_o[1] = done1;
    c_o[1]    = c1;
    f_o[1]    = {zf1, cf1, sf1, of1};
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: actual %0h required %0h at %0t", name, d, act, exp, $time);
  endtask

  // Reference arithmetic: returns {C[8:0], ZF, CF, SF, OF} for width w.
  function automatic logic [12:0] model_op(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input int w);
    int unsigned mask, av, bv, r, c9;
    int unsigned sa, sb, sr;
    logic cf, of, zf, sf;
    mask = (1 << w) - 1;
    av = a & mask;
    bv = b & mask;
    sa = (av >> (w - 1)) & 1;
    sb = (bv >> (w - 1)) & 1;
    cf = 1'b0;
    of = 1'b0;
    r  = 0;
    case (op)
      3'd1: r = av & bv;
      3'd2: begin
        r  = av + bv;
        cf = ((r >> w) & 1) != 0;
        r  = r & mask;
        sr = (r >> (w - 1)) & 1;
        of = (sa == sb) && (sr != sa);
      end
      3'd3: r = ~(av | bv) & mask;
      3'd4: begin
        cf = av < bv;
        r  = (av - bv) & mask;
        sr = (r >> (w - 1)) & 1;
        of = (sa != sb) && (sr != sa);
      end
      3'd5: r = av | bv;
      3'd6: r = av ^ bv;
      default: r = 0;
    endcase
    zf = (r == 0);
    sf = ((r >> (w - 1)) & 1) != 0;
    c9 = r | (int'(cf) << w);
    return {c9[8:0], zf, cf, sf, of};
  endfunction

  int         m_rem  [2];
  logic       m_busy [2];
  logic       m_done [2];
  logic [8:0] m_c    [2];
  logic [8:0] p_c    [2];
  logic [3:0] m_f    [2];
  logic [3:0] p_f    [2];
  logic [12:0] mr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_rem[d] = 0; m_busy[d] = 1'b0; m_done[d] = 1'b0;
        m_c[d] = '0; p_c[d] = '0; m_f[d] = '0; p_f[d] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_busy[d]) begin
          m_rem[d]--;
          if (m_rem[d] == 0) begin
            m_busy[d] = 1'b0;
            m_done[d] = 1'b1;
            m_c[d]    = p_c[d];
            m_f[d]    = p_f[d];
          end
        end else begin
          m_done[d] = 1'b0;
          if (start_in[d] === 1'b1 && op_in[d] != 3'd0 && op_in[d] != 3'd7) begin
            mr        = model_op(op_in[d], a_in[d], b_in[d], (d == 0) ? 4 : 8);
            p_c[d]    = mr[12:4];
            p_f[d]    = mr[3:0];
            m_busy[d] = 1'b1;
            m_rem[d]  = 4;
            m_c[d]    = '0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int d = 0; d < 2; d++) begin
        check("busy", d, busy_o[d], m_busy[d]);
        check("done", d, done_o[d], m_done[d]);
        check("flags", d, f_o[d], m_f[d]);
        if (!m_busy[d]) check("C", d, c_o[d], m_c[d]);
      end
    end
  end

  task automatic issue(input int d, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    start_in[d] = 1'b1;
    op_in[d]    = op;
    a_in[d]     = a;
    b_in[d]     = b;
    @(negedge clk);
    start_in[d] = 1'b0;
    op_in[d]    = 3'($urandom_range(0, 7));
    a_in[d]     = 8'($urandom);
    b_in[d]     = 8'($urandom);
  endtask

  task automatic wait_done(input int d, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done_o[d] && lat < 20) begin
      if (busy_o[d]) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (!done_o[d]) check("done_timeout", d, done_o[d], 1);
  endtask

  task automatic check_res(input int d, input string name, input logic [8:0] ec, input logic [3:0] ef);
    check({name, " C"}, d, c_o[d], ec);
    check({name, " flags"}, d, f_o[d], ef);
  endtask

  int lat, bcnt;
  logic [2:0] lop [4];
  logic [8:0] lres [4];
  logic [3:0] lflg [4];

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_in[d] = 1'b0; op_in[d] = '0; a_in[d] = '0; b_in[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset busy", d, busy_o[d], 0);
      check("reset done", d, done_o[d], 0);
      check_res(d, "reset", 9'h000, 4'b0000);
    end
    rst = 1'b0;
    @(negedge clk);

    // Flags are {ZF, CF, SF, OF}.
    issue(0, 3'b010, 8'h0F, 8'h01);
    wait_done(0, lat, bcnt);
    check("add F+1 latency", 0, lat, 4);
    check("add F+1 busy cycles", 0, bcnt, 4);
    check_res(0, "add F+1", 9'h010, 4'b1100);
    @(negedge clk);

    issue(0, 3'b010, 8'h07, 8'h01);
    wait_done(0, lat, bcnt);
    check_res(0, "add 7+1", 9'h008, 4'b0011);
    @(negedge clk);

    issue(0, 3'b100, 8'h03, 8'h05);
    wait_done(0, lat, bcnt);
    check_res(0, "sub 3-5", 9'h01E, 4'b0110);
    @(negedge clk);

    // Abort during the second RUN cycle, with bit0 of C already set.
    issue(0, 3'b010, 8'h05, 8'h00);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", 0, busy_o[0], 0);
    check("abort done", 0, done_o[0], 0);
    check_res(0, "abort", 9'h000, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue(0, 3'b010, 8'h06, 8'h02);
    wait_done(0, lat, bcnt);
    check("post-abort latency", 0, lat, 4);
    check_res(0, "post-abort add 6+2", 9'h008, 4'b0011);
    @(negedge clk);

    lop[0] = 3'b001; lres[0] = 9'h002; lflg[0] = 4'b0000;
    lop[1] = 3'b011; lres[1] = 9'h001; lflg[1] = 4'b0000;
    lop[2] = 3'b101; lres[2] = 9'h00E; lflg[2] = 4'b0010;
    lop[3] = 3'b110; lres[3] = 9'h00C; lflg[3] = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      issue(0, lop[i], 8'h0A, 8'h06);
      wait_done(0, lat, bcnt);
      check_res(0, $sformatf("logic op %0d", lop[i]), lres[i], lflg[i]);
      @(negedge clk);
    end

    // Start while busy must be ignored.
    issue(0, 3'b010, 8'h02, 8'h03);
    start_in[0] = 1'b1; op_in[0] = 3'b110; a_in[0] = 8'h0F; b_in[0] = 8'h0F;
    @(negedge clk);
    start_in[0] = 1'b0;
    wait_done(0, lat, bcnt);
    check_res(0, "start mid-run ignored", 9'h005, 4'b0000);

    // Start in the DONE cycle is accepted.
    issue(0, 3'b101, 8'h01, 8'h02);
    check("back-to-back busy", 0, busy_o[0], 1);
    wait_done(0, lat, bcnt);
    check("back-to-back latency", 0, lat, 4);
    check_res(0, "back-to-back or", 9'h003, 4'b0000);

    issue(0, 3'b000, 8'h05, 8'h05);
    check("illegal 000 busy", 0, busy_o[0], 0);
    issue(0, 3'b111, 8'h05, 8'h05);
    check("illegal 111 busy", 0, busy_o[0], 0);
    check("illegal keeps C", 0, c_o[0], 9'h003);
    @(negedge clk);

    issue(1, 3'b010, 8'hFF, 8'h01);
    wait_done(1, lat, bcnt);
    check("w8 add latency", 1, lat, 4);
    check_res(1, "w8 add FF+01", 9'h100, 4'b1100);
    @(negedge clk);
    issue(1, 3'b100, 8'h80, 8'h01);
    wait_done(1, lat, bcnt);
    check_res(1, "w8 sub 80-01", 9'h07F, 4'b0001);
    @(negedge clk);

    repeat (800) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        start_in[d] = ($urandom_range(0, 2) == 0);
        op_in[d]    = 3'($urandom_range(0, 7));
        a_in[d]     = 8'($urandom);
        b_in[d]     = 8'($urandom);
      end
    end
    @(negedge clk);
    start_in[0] = 1'b0;
    start_in[1] = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_alu.md
# serial_alu

Parametrised multi-cycle digit-serial ALU. It computes AND, OR, NOR, XOR, ADD and SUB on WIDTH-bit operands, processing DIGIT bits per clock. It uses a start/busy/done handshake and produces zero, carry, sign and overflow flags at completion. It is the generalised successor of the team's 4-bit bit-serial ALU and sits between the operand registers and the result/flag register file.

## Interface
- WIDTH, 4, operand width in bits; ≥2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when the block can accept.
- opcode  input  3  operation select, sampled with start.
- A  input  WIDTH  operand A, sampled with start.
- B  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while RUN is in progress.
- done  output  1  one-cycle pulse; C and flags valid from this cycle.
- C  output  WIDTH+1  result; bit WIDTH = CF.
- ZF, CF, SF, OF  output  1 each  zero, carry/borrow, sign, signed overflow.

## Operation
- Opcodes: 001 AND, 010 ADD, 011 NOR, 100 SUB, 101 OR, 110 XOR. 000 and 111 are illegal: start is ignored and no state changes.
- FSM states:
  - IDLE: start with a legal opcode → RUN. Latch A, B and opcode; digit index k=0; clear C; carry = 1 for SUB (A + ~B + 1), else 0.
  - RUN: each cycle computes C[k*DIGIT +: DIGIT] from the latched operands and the carry, updates the carry, then k++. After slice N−1 (N = WIDTH/DIGIT), go to DONE.
  - DONE: assert done and update the flags. A legal start in this cycle is accepted (→ RUN, back-to-back); otherwise → IDLE.
- Flags are written only in DONE and hold until the next DONE:
  - ZF = (C[WIDTH-1:0] == 0).
  - SF = C[WIDTH-1].
  - ADD: CF = final carry. SUB: CF = ~final carry (borrow).
  - OF = carry into MSB XOR carry out of MSB, for ADD/SUB only.
  - Logic ops: CF = OF = 0, and C[WIDTH] = 0.
- Latched operands are used throughout; A, B and opcode may change freely during RUN.
- start while busy is ignored.
- Reset mid-operation aborts: state → IDLE, no done pulse.

## Timing
- Reset values: busy=0, done=0, C=0, ZF=CF=SF=OF=0, state IDLE, k=0.
- Let E0 be the edge that samples start. busy is high from E0 to EN; slice j is written at edge E(j+1).
- done is high for the single cycle after EN. C and flags are valid in that cycle and hold afterwards.
- Latency start→done is N = WIDTH/DIGIT cycles. Throughput with back-to-back starts is one operation per N+1 cycles.
- Partial C bits are visible during RUN; they are not valid until done.
- C is cleared on the edge that accepts a new start.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_AND, OP_ADD, OP_NOR, OP_SUB, OP_OR, OP_XOR);
  - FSM state encodings (ST_IDLE, ST_RUN, ST_DONE, 2 bits);
  - the flag index constants.
- Sub-module alu_digit_slice: combinational DIGIT-bit logic/adder slice. Inputs: a, b, cin, opcode. Outputs: y, cout, and carry-into-MSB for overflow. It is instantiated once.
- The top level holds the FSM, the digit counter ($clog2(N)+1 bits), the operand latches, the result register and the flag registers.

## Test plan
- WIDTH=4, DIGIT=1, ADD F+1 → C=5'b10000, ZF=1, CF=1, SF=0, OF=0. done asserts exactly 4 cycles after the start edge; busy is high for 4 cycles.
- ADD 7+1 → C[3:0]=8, SF=1, OF=1, CF=0. SUB 3−5 → C[3:0]=E, CF=1, SF=1, OF=0, ZF=0.
- A=1010, B=0110: AND → 0010; NOR → 0001; OR → 1110; XOR → 1100; ZF=0 and CF=OF=0 for all four.
- Start issued mid-RUN with different operands → ignored, original result unchanged. Start in the DONE cycle → accepted, second done after N more cycles. Opcode 000 → busy stays 0.
- Assert rst at RUN cycle 2 → busy/done/C/flags go to 0 immediately, no done pulse; the next start completes normally.
- WIDTH=8, DIGIT=2, ADD FF+01 → C=9'h100, ZF=1, CF=1, done 4 cycles after the start edge. SUB 80−01 → 7F, OF=1, SF=0.
